mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port opr_a_md_i, input, 32 bits: operand A; multiplicand or dividend.
REQ-004 SHALL have port opr_b_md_i, input, 32 bits: operand B; multiplier or divisor.
REQ-005 SHALL have port op_md_i, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port start_md_i, input, 1 bit: request to begin an operation.
REQ-007 SHALL have port wr_hi_md_i, input, 1 bit: MTHI strobe; loads opr_a_md_i into HI.
REQ-008 SHALL have port wr_lo_md_i, input, 1 bit: MTLO strobe; loads opr_a_md_i into LO.
REQ-009 SHALL have port busy_md_o, output, 1 bit: operation in progress.
REQ-010 SHALL have port done_md_o, output, 1 bit: one-cycle pulse on completion.
REQ-011 SHALL have port hi_md_o, output, 32 bits: architectural HI register.
REQ-012 SHALL have port lo_md_o, output, 32 bits: architectural LO register.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL accept start_md_i only in IDLE or DONE; SHALL then latch operands and op, clear iteration counter, and enter RUN.
REQ-015 SHALL ignore start_md_i, wr_hi_md_i, wr_lo_md_i and all operand changes while in RUN.
REQ-016 SHALL perform one radix-2 iteration per cycle in RUN, using shift-add for multiply and restoring subtract for divide, for exactly 32 iterations (counter 0..31).
REQ-017 SHALL, on the edge where counter==31, write the final result to HI/LO and enter DONE; DONE lasts exactly one cycle, then IDLE unless a new start is accepted.
REQ-018 SHALL assert busy_md_o iff state==RUN; done_md_o iff state==DONE. Latency: start sampled at edge E0 -> done_md_o high in the cycle after edge E32.
REQ-019 SHALL hold hi_md_o/lo_md_o at previous values throughout RUN; partial results are kept in separate working registers.
REQ-020 Multiply SHALL produce a 64-bit product: HI=bits[63:32], LO=bits[31:0]; MULT signed, MULTU unsigned.
REQ-021 Divide SHALL produce LO=quotient and HI=remainder; DIV signed with truncation toward zero, remainder taking the sign of the dividend; DIVU unsigned.
REQ-022 Signed ops SHALL iterate on magnitudes and apply sign correction in the final write cycle, with no extra latency.
REQ-023 Divide by zero (any divide op) SHALL complete with normal latency, giving LO=32'hFFFF_FFFF and HI=dividend.
REQ-024 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL give LO=32'h8000_0000, HI=0.
REQ-025 In IDLE/DONE, wr_hi_md_i and wr_lo_md_i SHALL update HI/LO at the next edge; both asserted together SHALL load both.
REQ-026 If start_md_i coincides with wr_hi_md_i/wr_lo_md_i, start SHALL take priority and the write SHALL be dropped.

Reset
REQ-027 reset SHALL immediately force IDLE, busy_md_o=0, done_md_o=0, hi_md_o=0, lo_md_o=0, and clear the counter and working registers.
REQ-028 reset asserted mid-RUN SHALL abort the operation with no HI/LO update; the first start after reset deassertion SHALL behave normally.

Verification
REQ-029 MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> busy 32 cycles, done 1 cycle, HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-030 MULT A=-7, B=3 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB; DIV A=-7, B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
REQ-031 DIVU A=100, B=0 -> LO=32'hFFFF_FFFF, HI=100; DIV 32'h8000_0000 / -1 -> LO=32'h8000_0000, HI=0.
REQ-032 During RUN: pulse start, wr_hi, and change operands -> result unaffected, HI/LO unchanged until the completion edge.
REQ-033 In IDLE, wr_hi with A=32'h1234_5678 -> HI=32'h1234_5678 next cycle; start together with wr_lo -> LO write dropped, operation runs.
REQ-034 Assert reset at iteration 15 -> busy/done=0 and HI/LO=0 immediately; a new MULTU 3*5 then completes with LO=15, HI=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit with architectural HI/LO registers.
// Radix-2: one shift-add (multiply) or restoring-subtract (divide) step per
// cycle for 32 cycles. Signed operations iterate on magnitudes and fix the
// signs in the same cycle that writes HI/LO.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] opr_a_md_i,
  input  logic [31:0] opr_b_md_i,
  input  logic [1:0]  op_md_i,
  input  logic        start_md_i,
  input  logic        wr_hi_md_i,
  input  logic        wr_lo_md_i,
  output logic        busy_md_o,
  output logic        done_md_o,
  output logic [31:0] hi_md_o,
  output logic [31:0] lo_md_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  // Working registers: {wh,wl} is the product accumulator for multiply,
  // or {remainder, shifting dividend/quotient} for divide.
  logic [31:0] wh_q, wh_d, wl_q, wl_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [31:0] mag_q, mag_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;      // product / quotient must be negated
  logic        neg_rem_q, neg_rem_d;  // remainder takes dividend sign
  logic        div0_q, div0_d;

  // Operand decode for the start cycle.
  logic        op_signed, sa, sb;
  logic [31:0] abs_a, abs_b;

  assign op_signed = ~op_md_i[0];
  assign sa        = op_signed & opr_a_md_i[31];
  assign sb        = op_signed & opr_b_md_i[31];
  assign abs_a     = sa ? (32'd0 - opr_a_md_i) : opr_a_md_i;
  assign abs_b     = sb ? (32'd0 - opr_b_md_i) : opr_b_md_i;

  // Single iteration datapath.
  logic [32:0] mul_sum;
  logic [32:0] div_r;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Compute the next working value for one radix-2 step.
  always_comb begin
    mul_sum  = {1'b0, wh_q} + {1'b0, (wl_q[0] ? mag_q : 32'd0)};
    div_r    = {wh_q, wl_q[31]};
    div_ge   = (div_r >= {1'b0, mag_q});
    div_diff = div_r[31:0] - mag_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_r[31:0];
      step_lo = {wl_q[30:0], div_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], wl_q[31:1]};
    end
  end

  // Sign correction applied to the final step's result.
  always_comb begin
    prod_fix = neg_q ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};
    quo_fix  = div0_q ? 32'hFFFF_FFFF :
               (neg_q ? (32'd0 - step_lo) : step_lo);
    rem_fix  = neg_rem_q ? (32'd0 - step_hi) : step_hi;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wh_d      = wh_q;
    wl_d      = wl_q;
    mag_d     = mag_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_md_i) begin
          // Start wins over any coincident MTHI/MTLO.
          state_d   = RUN;
          cnt_d     = 5'd0;
          is_div_d  = op_md_i[1];
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          div0_d    = (opr_b_md_i == 32'd0);
          wh_d      = 32'd0;
          wl_d      = op_md_i[1] ? abs_a : abs_b;
          mag_d     = op_md_i[1] ? abs_b : abs_a;
        end else begin
          if (wr_hi_md_i) hi_d = opr_a_md_i;
          if (wr_lo_md_i) lo_d = opr_a_md_i;
        end
      end
      RUN: begin
        wh_d  = step_hi;
        wl_d  = step_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      wh_q      <= 32'd0;
      wl_q      <= 32'd0;
      mag_q     <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wh_q      <= wh_d;
      wl_q      <= wl_d;
      mag_q     <= mag_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign busy_md_o = (state_q == RUN);
  assign done_md_o = (state_q == DONE);
  assign hi_md_o   = hi_q;
  assign lo_md_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic model.
module tb_mult_div_unit;

  logic        clk, reset;
  logic [31:0] a_i, b_i;
  logic [1:0]  op_i;
  logic        start, wr_hi, wr_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset),
    .opr_a_md_i(a_i), .opr_b_md_i(b_i), .op_md_i(op_i),
    .start_md_i(start), .wr_hi_md_i(wr_hi), .wr_lo_md_i(wr_lo),
    .busy_md_o(busy), .done_md_o(done), .hi_md_o(hi), .lo_md_o(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue one op at the current negedge; ends on the negedge where done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit perturb, input bit wlo);
    logic [63:0] exp;
    logic [31:0] h0, l0;
    int n;
    bit held;
    exp = model(op, a, b);
    h0 = hi; l0 = lo;
    op_i = op; a_i = a; b_i = b; start = 1'b1; wr_lo = wlo;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    n = 0; held = 1'b1;
    while (busy && n < 40) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      if (perturb && n == 5) begin
        start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1;
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
      end
      if (perturb && n == 6) begin start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; end
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'd32);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("hilo_held", {63'd0, held}, 64'd1);
    chk("result", {hi, lo}, exp);
  endtask

  logic [31:0] edges [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'h2};

  function automatic logic [31:0] pick();
    if ($urandom_range(3) == 0) return edges[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1; a_i = '0; b_i = '0; op_i = '0;
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    #1;
    chk("rst_state", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_idle", {busy, done, hi, lo}, 66'd0);

    // Directed corner cases.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b00, -32'sd7, 32'd3, 0, 0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b10, -32'sd7, 32'd2, 0, 0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd0, 0, 0);
    chk("divu_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(2'b10, -32'sd9, 32'd0, 0, 0);
    @(negedge clk);
    chk("done_one_cycle", {busy, done}, 2'b00);

    // MTHI / MTLO in IDLE.
    a_i = 32'h1234_5678; wr_hi = 1'b1;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi", 64'(hi), 64'h1234_5678);
    a_i = 32'hCAFE_0001; wr_hi = 1'b1; wr_lo = 1'b1;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mthi_mtlo", {hi, lo}, 64'hCAFE_0001_CAFE_0001);

    // Start with coincident MTLO: write dropped, op runs.
    run_op(2'b01, 32'h0000_0011, 32'h0000_0003, 0, 1);
    // Inputs disturbed during RUN.
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1, 0);
    run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1, 0);

    // Random ops, back-to-back (each start accepted in DONE).
    for (int i = 0; i < 150; i++)
      run_op(2'($urandom), pick(), pick(), ($urandom_range(7) == 0), 0);
    @(negedge clk);

    // Reset mid-run aborts.
    op_i = 2'b01; a_i = 32'd1000; b_i = 32'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_midrun", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after", {busy, done, hi, lo}, 66'd0);
    run_op(2'b01, 32'd3, 32'd5, 0, 0);
    chk("multu_3x5", {hi, lo}, 64'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
